// File: rtl/manchester_pkg.sv
// Symbol constants and decoder state encoding shared by the Manchester
// link byte escaper and unescaper.
package manchester_pkg;

    localparam int          SYMBOL_WIDTH           = 8;
    localparam logic [7:0]  ESCAPED_SYMBOL_DEFAULT = 8'hD5;
    localparam logic [7:0]  ESCAPE_SYMBOL_DEFAULT  = 8'hE5;
    localparam logic [7:0]  REPLACE_SYMBOL_DEFAULT = 8'hF5;

    typedef enum logic {
        REGULAR = 1'b0,
        ESCAPED = 1'b1
    } esc_state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-Stream output register carrying tdata/tlast/tuser.
// The owner decides when to load; otherwise the slot drains on tready.
module axis_reg_slice #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_user,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser
);

    logic [DATA_WIDTH-1:0] data_reg;
    logic                  valid_reg;
    logic                  last_reg;
    logic                  user_reg;

    // Space is available when the slot is empty or is being drained this cycle.
    assign in_ready = !valid_reg || m_axis_tready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            user_reg  <= 1'b0;
        end else if (load) begin
            data_reg  <= in_data;
            valid_reg <= 1'b1;
            last_reg  <= in_last;
            user_reg  <= in_user;
        end else if (m_axis_tready) begin
            valid_reg <= 1'b0;
        end
    end

    assign m_axis_tdata  = data_reg;
    assign m_axis_tvalid = valid_reg;
    assign m_axis_tlast  = last_reg;
    assign m_axis_tuser  = user_reg;

endmodule

// File: rtl/manchester_unescape.sv
// Receive-side unescaper: strips escape prefixes from an AXI-Stream byte
// stream, restores reserved bytes and tags protocol violations in tuser.
module manchester_unescape
    import manchester_pkg::*;
#(
    parameter int                    DATA_WIDTH     = SYMBOL_WIDTH,
    parameter logic [DATA_WIDTH-1:0] ESCAPED_SYMBOL = ESCAPED_SYMBOL_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] ESCAPE_SYMBOL  = ESCAPE_SYMBOL_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] REPLACE_SYMBOL = REPLACE_SYMBOL_DEFAULT,
    parameter int                    ERR_CNT_WIDTH  = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    esc_state_t              state_reg;
    esc_state_t              state_next;
    logic                    in_ready;
    logic                    beat;
    logic                    load;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_last;
    logic                    out_user;
    logic [ERR_CNT_WIDTH-1:0] err_count_reg;

    assign s_axis_tready = in_ready;
    assign beat          = s_axis_tvalid && in_ready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg <= REGULAR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        out_data   = s_axis_tdata;
        out_last   = s_axis_tlast;
        out_user   = 1'b0;
        if (beat) begin
            case (state_reg)
                REGULAR: begin
                    if (s_axis_tdata == ESCAPE_SYMBOL) begin
                        if (s_axis_tlast) begin
                            // Escape cut off by end of frame: emit it so tlast is not lost.
                            load     = 1'b1;
                            out_user = 1'b1;
                        end else begin
                            state_next = ESCAPED;
                        end
                    end else begin
                        load     = 1'b1;
                        out_user = (s_axis_tdata == ESCAPED_SYMBOL);
                    end
                end
                ESCAPED: begin
                    load       = 1'b1;
                    state_next = REGULAR;
                    if (s_axis_tdata == REPLACE_SYMBOL) begin
                        out_data = ESCAPED_SYMBOL;
                    end else if (s_axis_tdata != ESCAPE_SYMBOL) begin
                        out_user = 1'b1;
                    end
                end
                default: begin
                    state_next = REGULAR;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err_count_reg <= '0;
        end else if (load && out_user && (err_count_reg != '1)) begin
            err_count_reg <= err_count_reg + 1'b1;
        end
    end

    assign err_count = err_count_reg;

    axis_reg_slice #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_slice (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .load          (load),
        .in_data       (out_data),
        .in_last       (out_last),
        .in_user       (out_user),
        .in_ready      (in_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

endmodule
